// File: rtl/alu_arbiter_pkg.sv
// +--------------------------------------------------------------------------+
// | ALU_FNS: ALU function encodings and arbiter request types.  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

package ALU_FNS;

  typedef enum logic [2:0] {
    ADD_SUB = 3'b000,
    SLL     = 3'b001,
    SLT     = 3'b010,
    SLTU    = 3'b011,
    XOR     = 3'b100,
    SRL_SRA = 3'b101,
    OR      = 3'b110,
    AND     = 3'b111
  } alu_fn_t;

  typedef logic [6:0] funct7_t;

  localparam funct7_t SUB_SRA = 7'b0100000;

  typedef struct packed {
    alu_fn_t fn;
    funct7_t funct7;
  } alu_req_t;

  localparam int ALU_ARB_MAX_REQ = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_arbiter_if.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter_if: requester ports plus tagged response channel.  Rev 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface alu_arbiter_if
  import ALU_FNS::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) ();

  localparam int ID_W = $clog2(NUM_REQ);

  logic    [NUM_REQ-1:0]            req_valid;
  logic    [NUM_REQ-1:0]            req_ready;
  alu_fn_t [NUM_REQ-1:0]            req_fn;
  funct7_t [NUM_REQ-1:0]            req_funct7;
  logic    [NUM_REQ-1:0][WIDTH-1:0] req_a;
  logic    [NUM_REQ-1:0][WIDTH-1:0] req_b;
  logic                             rsp_valid;
  logic                             rsp_ready;
  logic    [ID_W-1:0]               rsp_id;
  logic    [WIDTH-1:0]              rsp_data;

  modport master (
    output req_valid, req_fn, req_funct7, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_fn, req_funct7, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

`default_nettype wire

// File: rtl/alu.sv
// +--------------------------------------------------------------------------+
// | alu: combinational RV32-style integer ALU.  Rev 1.0                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu
  import ALU_FNS::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_fn_t          fn,
  input  funct7_t          funct7,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic w_alt;
  assign w_alt = (funct7 == SUB_SRA);

  always_comb begin
    y = '0;
    case (fn)
      ADD_SUB: y = w_alt ? (a - b) : (a + b);
      SLL:     y = a << b;
      SLT:     y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      SLTU:    y = {{(WIDTH-1){1'b0}}, (a < b)};
      XOR:     y = a ^ b;
      SRL_SRA: y = w_alt ? WIDTH'($signed(a) >>> b) : (a >> b);
      OR:      y = a | b;
      AND:     y = a & b;
      default: y = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter: combinational round-robin pick starting at ptr.  Rev 1.0     |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             en,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  int               w_sum;
  logic [IDX_W-1:0] w_idx;

  // Scan upward from ptr with wrap; the first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = (int'(ptr) + k) % N;
      w_idx = IDX_W'(w_sum);
      if (en && !gnt_any && req[w_idx]) begin
        gnt_any    = 1'b1;
        gnt[w_idx] = 1'b1;
        gnt_idx    = w_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_arbiter: shares one ALU among NUM_REQ requesters, registered result. |
// | Optional macro ALU_ARB_STATS_EN adds grant/stall counters.  Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_arbiter
  import ALU_FNS::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  alu_arbiter_if.slave              bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]  grant_count,
  output logic [15:0]               stall_count
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [WIDTH-1:0] r_rsp_data;

  logic               w_grant_en;
  logic [NUM_REQ-1:0] w_gnt;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_accept;
  alu_req_t           w_ctl;
  logic [WIDTH-1:0]   w_a;
  logic [WIDTH-1:0]   w_b;
  logic [WIDTH-1:0]   w_y;

  // HOLD with rsp_ready set frees the slot in the same cycle.
  assign w_grant_en = !rst && ((r_state == ST_IDLE) || bus.rsp_ready);

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr (
    .req     (bus.req_valid),
    .ptr     (r_ptr),
    .en      (w_grant_en),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .gnt_any (w_accept)
  );

  assign bus.req_ready = w_gnt;

  assign w_ctl.fn     = bus.req_fn[w_gnt_idx];
  assign w_ctl.funct7 = bus.req_funct7[w_gnt_idx];
  assign w_a          = bus.req_a[w_gnt_idx];
  assign w_b          = bus.req_b[w_gnt_idx];

  alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .fn     (w_ctl.fn),
    .funct7 (w_ctl.funct7),
    .a      (w_a),
    .b      (w_b),
    .y      (w_y)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      w_state_nxt = ST_HOLD;
    end else if ((r_state == ST_HOLD) && bus.rsp_ready) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_ptr      <= (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : (w_gnt_idx + 1'b1);
      r_rsp_id   <= w_gnt_idx;
      r_rsp_data <= w_y;
    end
  end

  assign bus.rsp_valid = (r_state == ST_HOLD);
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_count <= '0;
      stall_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] && (grant_count[i] != 16'hFFFF)) begin
          grant_count[i] <= grant_count[i] + 16'd1;
        end
      end
      if ((r_state == ST_HOLD) && !bus.rsp_ready && (stall_count != 16'hFFFF)) begin
        stall_count <= stall_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter: directed vector table plus reset and stats sequences.    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_arbiter;
  import ALU_FNS::*;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

`ifdef ALU_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] grant_count;
  logic [15:0]              stall_count;
`endif

  alu_arbiter #(
    .WIDTH   (WIDTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_count (grant_count),
    .stall_count (stall_count)
`endif
  );

  typedef struct {
    logic [1:0]  v;
    alu_fn_t     fn0;
    funct7_t     f0;
    logic [31:0] a0;
    logic [31:0] b0;
    alu_fn_t     fn1;
    funct7_t     f1;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr;
    logic [1:0]  exp_rdy;
    logic        exp_vld;
    logic        exp_id;
    logic [31:0] exp_data;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t t);
    bus.req_valid     = t.v;
    bus.req_fn[0]     = t.fn0;
    bus.req_funct7[0] = t.f0;
    bus.req_a[0]      = t.a0;
    bus.req_b[0]      = t.b0;
    bus.req_fn[1]     = t.fn1;
    bus.req_funct7[1] = t.f1;
    bus.req_a[1]      = t.a1;
    bus.req_b[1]      = t.b1;
    bus.rsp_ready     = t.rr;
  endtask

  function automatic vec_t mk(
    input logic [1:0] v,
    input alu_fn_t fn0, input funct7_t f0, input logic [31:0] a0, input logic [31:0] b0,
    input alu_fn_t fn1, input funct7_t f1, input logic [31:0] a1, input logic [31:0] b1,
    input logic rr, input logic [1:0] exp_rdy, input logic exp_vld,
    input logic exp_id, input logic [31:0] exp_data);
    vec_t t;
    t.v = v; t.fn0 = fn0; t.f0 = f0; t.a0 = a0; t.b0 = b0;
    t.fn1 = fn1; t.f1 = f1; t.a1 = a1; t.b1 = b1; t.rr = rr;
    t.exp_rdy = exp_rdy; t.exp_vld = exp_vld; t.exp_id = exp_id; t.exp_data = exp_data;
    return t;
  endfunction

  initial begin
    vec_t idle;

    //          v      fn0      f0       a0            b0      fn1      f1       a1     b1     rr    rdy    vld   id    data
    vecs[0]  = mk(2'b01, ADD_SUB, 7'h00,   32'd5,        32'd3,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h8);
    vecs[1]  = mk(2'b11, ADD_SUB, SUB_SRA, 32'd10,       32'd4,  XOR,     7'h00,   32'hF0, 32'hFF, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0F);
    vecs[2]  = mk(2'b11, ADD_SUB, SUB_SRA, 32'd10,       32'd4,  XOR,     7'h00,   32'hF0, 32'hFF, 1'b1, 2'b01, 1'b1, 1'b0, 32'h6);
    vecs[3]  = mk(2'b11, ADD_SUB, SUB_SRA, 32'd10,       32'd4,  XOR,     7'h00,   32'hF0, 32'hFF, 1'b1, 2'b10, 1'b1, 1'b1, 32'h0F);
    vecs[4]  = mk(2'b11, ADD_SUB, SUB_SRA, 32'd10,       32'd4,  XOR,     7'h00,   32'hF0, 32'hFF, 1'b1, 2'b01, 1'b1, 1'b0, 32'h6);
    vecs[5]  = mk(2'b01, AND,     7'h00,   32'hC,        32'hA,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h8);
    vecs[6]  = mk(2'b10, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h1, 32'h2, 1'b0, 2'b00, 1'b1, 1'b0, 32'h8);
    vecs[7]  = mk(2'b10, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h1, 32'h2, 1'b0, 2'b00, 1'b1, 1'b0, 32'h8);
    vecs[8]  = mk(2'b10, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h1, 32'h2, 1'b0, 2'b00, 1'b1, 1'b0, 32'h8);
    vecs[9]  = mk(2'b10, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h1, 32'h2, 1'b1, 2'b10, 1'b1, 1'b1, 32'h3);
    vecs[10] = mk(2'b01, SLL,     7'h00,   32'h1,        32'd4,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b01, 1'b1, 1'b0, 32'h10);
    vecs[11] = mk(2'b10, ADD_SUB, 7'h00,   32'h0,        32'h0,  SRL_SRA, SUB_SRA, 32'h80000000, 32'd4, 1'b1, 2'b10, 1'b1, 1'b1, 32'hF8000000);
    vecs[12] = mk(2'b00, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    vecs[13] = mk(2'b00, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    vecs[14] = mk(2'b01, SLT,     7'h00,   32'hFFFFFFFF, 32'h1,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b0, 2'b01, 1'b1, 1'b0, 32'h1);
    vecs[15] = mk(2'b00, ADD_SUB, 7'h00,   32'h0,        32'h0,  ADD_SUB, 7'h00,   32'h0, 32'h0, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);

    idle = mk(2'b00, ADD_SUB, 7'h00, 32'h0, 32'h0, ADD_SUB, 7'h00, 32'h0, 32'h0,
              1'b0, 2'b00, 1'b0, 1'b0, 32'h0);

    // Reset with both requesters valid: no grant may leak through.
    apply(idle);
    bus.req_valid = 2'b11;
    rst = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_rsp_id",    32'(bus.rsp_id),    32'h0);
    chk("rst_rsp_data",  bus.rsp_data,       32'h0);
    apply(idle);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(bus.req_ready), 32'(vecs[i].exp_rdy));
      tick();
      chk($sformatf("v%0d_rsp_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        chk($sformatf("v%0d_rsp_id", i),   32'(bus.rsp_id), 32'(vecs[i].exp_id));
        chk($sformatf("v%0d_rsp_data", i), bus.rsp_data,    vecs[i].exp_data);
      end
    end

    // Reset while holding a result: it must be discarded, pointer back to 0.
    apply(idle);
    bus.req_valid = 2'b01;
    bus.req_fn[0] = AND;
    bus.req_a[0]  = 32'hC;
    bus.req_b[0]  = 32'hA;
    tick();
    bus.req_valid = 2'b00;
    chk("hold_pre_rst_valid", 32'(bus.rsp_valid), 32'h1);
    chk("hold_pre_rst_data",  bus.rsp_data,       32'h8);
    rst = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'h0);
    tick();
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_mid_rsp_data",  bus.rsp_data,       32'h0);
    chk("rst_mid_rsp_id",    32'(bus.rsp_id),    32'h0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(bus.req_ready), 32'h1);
    tick();
    chk("post_rst_rsp_id",   32'(bus.rsp_id),   32'h0);
    chk("post_rst_rsp_data", bus.rsp_data,      32'h8);
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b1;
    tick();
    chk("post_rst_drain", 32'(bus.rsp_valid), 32'h0);

`ifdef ALU_ARB_STATS_EN
    apply(idle);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats_rst_g0",    32'(grant_count[0]), 32'h0);
    chk("stats_rst_stall", 32'(stall_count),    32'h0);
    bus.req_valid = 2'b10;
    bus.req_fn[1] = ADD_SUB;
    bus.req_a[1]  = 32'd7;
    bus.req_b[1]  = 32'd1;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    chk("stats_g1",    32'(grant_count[1]), 32'd5);
    chk("stats_g0",    32'(grant_count[0]), 32'd0);
    chk("stats_stall", 32'(stall_count),    32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("stats_clr_g1",    32'(grant_count[1]), 32'h0);
    chk("stats_clr_stall", 32'(stall_count),    32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
